// File: rtl/zeroheti_rst_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : zeroheti_rst_seq                                              |
// | Purpose  : FPGA-top reset sequencer: PLL lock, button and software reset |
// |            sources combined into staged active-low resets and a cause.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module zeroheti_rst_seq #(
    parameter int NUM_OUT         = 2,
    parameter int NUM_LOCKS       = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STRETCH_CYCLES  = 64,
    parameter int STAGE_DELAY     = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ext_rst_i,
    input  logic [NUM_LOCKS-1:0] lock_i,
    input  logic                 sw_rst_req_i,
    output logic [NUM_OUT-1:0]   rst_no,
    output logic                 rst_done_o,
    output logic [1:0]           rst_cause_o
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int STR_W = $clog2(STRETCH_CYCLES + 1);
    localparam int STG_W = $clog2(STAGE_DELAY + 1);
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [DEB_W-1:0] c_deb_max  = DEB_W'(DEBOUNCE_CYCLES);
    localparam logic [STR_W-1:0] c_str_last = STR_W'(STRETCH_CYCLES - 1);
    localparam logic [STG_W-1:0] c_stg_last = STG_W'(STAGE_DELAY - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_OUT - 1);

    localparam logic [1:0] c_cause_lock = 2'd1;
    localparam logic [1:0] c_cause_btn  = 2'd2;
    localparam logic [1:0] c_cause_sw   = 2'd3;

    typedef enum logic [1:0] {
        S_WAIT_LOCK = 2'd0,
        S_STRETCH   = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0]                r_ext_sync;
    logic [SYNC_STAGES-1:0][NUM_LOCKS-1:0] r_lock_sync;
    logic [DEB_W-1:0]                      r_deb_cnt;

    state_t             r_state,   w_state_nxt;
    logic [NUM_OUT-1:0] r_rst_n,   w_rst_n_nxt;
    logic               r_done,    w_done_nxt;
    logic [1:0]         r_cause,   w_cause_nxt;
    logic [STR_W-1:0]   r_str_cnt, w_str_cnt_nxt;
    logic [STG_W-1:0]   r_stg_cnt, w_stg_cnt_nxt;
    logic [IDX_W-1:0]   r_idx,     w_idx_nxt;

    logic w_ext_synced;
    logic w_lock_ok;
    logic w_btn;
    logic w_lock_lost;
    logic w_sw_fault;
    logic w_fault;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ext_sync  <= '0;
            r_lock_sync <= '0;
        end else begin
            r_ext_sync  <= {r_ext_sync[SYNC_STAGES-2:0], ext_rst_i};
            r_lock_sync <= {r_lock_sync[SYNC_STAGES-2:0], lock_i};
        end
    end

    assign w_ext_synced = r_ext_sync[SYNC_STAGES-1];
    assign w_lock_ok    = &r_lock_sync[SYNC_STAGES-1];

    // Saturating debounce: the button counts as pressed only after a full run of high samples
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_deb_cnt <= '0;
        end else if (!w_ext_synced) begin
            r_deb_cnt <= '0;
        end else if (r_deb_cnt != c_deb_max) begin
            r_deb_cnt <= r_deb_cnt + DEB_W'(1);
        end
    end

    assign w_btn       = (r_deb_cnt == c_deb_max);
    assign w_lock_lost = !w_lock_ok && (r_state != S_WAIT_LOCK);
    assign w_sw_fault  = sw_rst_req_i && (r_state == S_RUN);
    assign w_fault     = w_lock_lost || w_btn || w_sw_fault;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_WAIT_LOCK;
            r_rst_n   <= '0;
            r_done    <= 1'b0;
            r_cause   <= 2'd0;
            r_str_cnt <= '0;
            r_stg_cnt <= '0;
            r_idx     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rst_n   <= w_rst_n_nxt;
            r_done    <= w_done_nxt;
            r_cause   <= w_cause_nxt;
            r_str_cnt <= w_str_cnt_nxt;
            r_stg_cnt <= w_stg_cnt_nxt;
            r_idx     <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rst_n_nxt   = r_rst_n;
        w_done_nxt    = r_done;
        w_cause_nxt   = r_cause;
        w_str_cnt_nxt = '0;
        w_stg_cnt_nxt = '0;
        w_idx_nxt     = r_idx;

        // A fault wins over any release scheduled for the same edge
        if (w_fault) begin
            w_rst_n_nxt = '0;
            w_done_nxt  = 1'b0;
            if (w_lock_lost) begin
                w_cause_nxt = c_cause_lock;
            end else if (w_btn) begin
                w_cause_nxt = c_cause_btn;
            end else begin
                w_cause_nxt = c_cause_sw;
            end
            w_state_nxt = (w_lock_lost || w_btn) ? S_WAIT_LOCK : S_STRETCH;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    if (w_lock_ok && !w_ext_synced) begin
                        w_state_nxt = S_STRETCH;
                    end
                end
                S_STRETCH: begin
                    if (r_str_cnt == c_str_last) begin
                        w_rst_n_nxt[0] = 1'b1;
                        if (NUM_OUT == 1) begin
                            w_state_nxt = S_RUN;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_state_nxt = S_RELEASE;
                            w_idx_nxt   = IDX_W'(1);
                        end
                    end else begin
                        w_str_cnt_nxt = r_str_cnt + STR_W'(1);
                    end
                end
                S_RELEASE: begin
                    if (r_stg_cnt == c_stg_last) begin
                        w_rst_n_nxt[r_idx] = 1'b1;
                        w_idx_nxt          = r_idx + IDX_W'(1);
                        if (r_idx == c_idx_last) begin
                            w_state_nxt = S_RUN;
                            w_done_nxt  = 1'b1;
                        end
                    end else begin
                        w_stg_cnt_nxt = r_stg_cnt + STG_W'(1);
                    end
                end
                S_RUN: begin
                    w_state_nxt = S_RUN;
                end
                default: begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_rst_n_nxt = '0;
                    w_done_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign rst_no      = r_rst_n;
    assign rst_done_o  = r_done;
    assign rst_cause_o = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_zeroheti_rst_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_zeroheti_rst_seq                                           |
// | Purpose  : Scoreboard bench: expected output transitions are queued with |
// |            their edge number; monitors pop them as the DUT outputs move. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_zeroheti_rst_seq;

    localparam int unsigned S     = 64;
    localparam int unsigned D     = 8;
    localparam int unsigned NEVER = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] ed;
        logic [1:0]  r;
        logic        d;
        logic [1:0]  c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_n1 = 1'b0;
    logic        ext0 = 1'b0;
    logic        sw0 = 1'b0;
    logic [0:0]  lock0 = 1'b1;
    logic [2:0]  lock1 = 3'b000;
    logic [1:0]  rst_no0;
    logic        done0;
    logic [1:0]  cause0;
    logic [0:0]  rst_no1;
    logic        done1;
    logic [1:0]  cause1;

    int unsigned cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    logic [4:0]  last0 = '0;
    logic [4:0]  last1 = '0;
    logic [4:0]  prev0 = '0;
    logic [4:0]  prev1 = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    zeroheti_rst_seq #(
        .NUM_OUT(2), .NUM_LOCKS(1), .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(16), .STRETCH_CYCLES(64), .STAGE_DELAY(8)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .ext_rst_i(ext0), .lock_i(lock0),
        .sw_rst_req_i(sw0), .rst_no(rst_no0), .rst_done_o(done0), .rst_cause_o(cause0)
    );

    zeroheti_rst_seq #(
        .NUM_OUT(1), .NUM_LOCKS(3), .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(16), .STRETCH_CYCLES(1), .STAGE_DELAY(8)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n1), .ext_rst_i(1'b0), .lock_i(lock1),
        .sw_rst_req_i(1'b0), .rst_no(rst_no1), .rst_done_o(done1), .rst_cause_o(cause1)
    );

    task automatic check(input string nm, input bit ok, input string got, input string want);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", nm, got, want);
    endtask

    // Only transitions are queued; a repeat of the last expected value is no event
    task automatic push0(input int unsigned ed, input logic [1:0] r, input logic d, input logic [1:0] c);
        if ({r, d, c} != last0) begin
            q0.push_back('{ed, r, d, c});
            last0 = {r, d, c};
        end
    endtask

    task automatic push1(input int unsigned ed, input logic r, input logic d, input logic [1:0] c);
        if ({1'b0, r, d, c} != last1) begin
            q1.push_back('{ed, {1'b0, r}, d, c});
            last1 = {1'b0, r, d, c};
        end
    endtask

    // Staged release for a sequence whose stretch began on edge t0, truncated by a fault at cut
    task automatic rel0(input int unsigned t0, input int unsigned cut, input logic [1:0] c);
        if (t0 + S < cut)     push0(t0 + S, 2'b01, 1'b0, c);
        if (t0 + S + D < cut) push0(t0 + S + D, 2'b11, 1'b1, c);
    endtask

    always @(negedge clk) begin : mon0
        logic [4:0] cur;
        exp_t x;
        cur = {rst_no0, done0, cause0};
        if (cur !== prev0) begin
            prev0 = cur;
            if (q0.size() == 0) begin
                check("dut0_unexpected", 1'b0, $sformatf("edge %0d out %b", cyc, cur), "no change");
            end else begin
                x = q0.pop_front();
                check("dut0_event", (x.ed == cyc) && (cur === {x.r, x.d, x.c}),
                      $sformatf("edge %0d out %b", cyc, cur),
                      $sformatf("edge %0d out %b", x.ed, {x.r, x.d, x.c}));
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic [4:0] cur;
        exp_t x;
        cur = {1'b0, rst_no1, done1, cause1};
        if (cur !== prev1) begin
            prev1 = cur;
            if (q1.size() == 0) begin
                check("dut1_unexpected", 1'b0, $sformatf("edge %0d out %b", cyc, cur), "no change");
            end else begin
                x = q1.pop_front();
                check("dut1_event", (x.ed == cyc) && (cur === {x.r, x.d, x.c}),
                      $sformatf("edge %0d out %b", cyc, cur),
                      $sformatf("edge %0d out %b", x.ed, {x.r, x.d, x.c}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned ed);
        while (cyc < ed) tick();
    endtask

    task automatic lock_drop(input int unsigned len);
        int unsigned e;
        e = cyc;
        push0(e + 3, 2'b00, 1'b0, 2'd1);
        rel0(e + len + 3, NEVER, 2'd1);
        lock0 = 1'b0;
        repeat (len) tick();
        lock0 = 1'b1;
        wait_until(e + len + 3 + S + D + 3);
    endtask

    task automatic button(input int unsigned len);
        int unsigned e;
        e = cyc;
        if (len >= 16) begin
            push0(e + 19, 2'b00, 1'b0, 2'd2);
            rel0(e + len + 4, NEVER, 2'd2);
        end
        ext0 = 1'b1;
        repeat (len) tick();
        ext0 = 1'b0;
        wait_until(e + len + 4 + S + D + 3);
    endtask

    // k>0 adds a second pulse landing on edge t0+k, which is still in the stretch phase
    task automatic sw(input int unsigned k);
        int unsigned e;
        e = cyc;
        push0(e + 1, 2'b00, 1'b0, 2'd3);
        rel0(e + 1, NEVER, 2'd3);
        sw0 = 1'b1;
        tick();
        sw0 = 1'b0;
        if (k > 0) begin
            repeat (k - 1) tick();
            sw0 = 1'b1;
            tick();
            sw0 = 1'b0;
        end
        wait_until(e + 1 + S + D + 3);
    endtask

    task automatic mid_release(input int unsigned off, input int unsigned len);
        int unsigned t0;
        int unsigned e;
        t0 = cyc + 1;
        e  = t0 + off - 3;
        push0(t0, 2'b00, 1'b0, 2'd3);
        rel0(t0, t0 + off, 2'd3);
        push0(t0 + off, 2'b00, 1'b0, 2'd1);
        rel0(e + len + 3, NEVER, 2'd1);
        sw0 = 1'b1;
        tick();
        sw0 = 1'b0;
        wait_until(e);
        lock0 = 1'b0;
        repeat (len) tick();
        lock0 = 1'b1;
        wait_until(e + len + 3 + S + D + 3);
    endtask

    task automatic por_mid_release();
        int unsigned t0;
        int unsigned e;
        t0 = cyc + 1;
        push0(t0, 2'b00, 1'b0, 2'd3);
        rel0(t0, t0 + S + 1, 2'd3);
        sw0 = 1'b1;
        tick();
        sw0 = 1'b0;
        wait_until(t0 + S + 2);
        #2;
        push0(cyc, 2'b00, 1'b0, 2'd0);
        rst_n = 1'b0;
        #1;
        check("async_reset", (rst_no0 === 2'b00) && (done0 === 1'b0) && (cause0 === 2'd0),
              $sformatf("rst_no=%b done=%b cause=%0d", rst_no0, done0, cause0), "rst_no=00 done=0 cause=0");
        tick();
        rst_n = 1'b1;
        e = cyc;
        rel0(e + 3, NEVER, 2'd0);
        wait_until(e + 3 + S + D + 3);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at edge %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int unsigned e;
        int unsigned b;
        int unsigned len;
        repeat (3) tick();
        check("reset_state_dut0", (rst_no0 === 2'b00) && (done0 === 1'b0) && (cause0 === 2'd0),
              $sformatf("rst_no=%b done=%b cause=%0d", rst_no0, done0, cause0), "rst_no=00 done=0 cause=0");
        check("reset_state_dut1", (rst_no1 === 1'b0) && (done1 === 1'b0) && (cause1 === 2'd0),
              $sformatf("rst_no=%b done=%b cause=%0d", rst_no1, done1, cause1), "rst_no=0 done=0 cause=0");
        e = cyc;
        rel0(e + 3, NEVER, 2'd0);
        rst_n = 1'b1;
        wait_until(e + 3 + S + D + 3);

        button(15);
        button(16);
        button(20);
        lock_drop(1);
        sw(0);
        sw(S);
        mid_release(S, 2);
        mid_release(S + D, 1);
        mid_release(3, 1);
        por_mid_release();

        for (int it = 0; it < 10; it++) begin
            case ($urandom_range(0, 3))
                0: lock_drop($urandom_range(1, 4));
                1: begin
                    if ($urandom_range(0, 1) == 1) button($urandom_range(1, 15));
                    else button($urandom_range(16, 24));
                end
                2: sw($urandom_range(0, S));
                default: mid_release($urandom_range(3, S + D), $urandom_range(1, 4));
            endcase
            repeat ($urandom_range(0, 5)) tick();
        end

        rst_n1 = 1'b1;
        repeat (5) tick();
        lock1 = 3'b011;
        repeat (10) tick();
        e = cyc;
        push1(e + 4, 1'b1, 1'b1, 2'd0);
        lock1 = 3'b111;
        wait_until(e + 8);
        for (int it = 0; it < 4; it++) begin
            b   = $urandom_range(0, 2);
            len = $urandom_range(1, 4);
            e   = cyc;
            push1(e + 3, 1'b0, 1'b0, 2'd1);
            push1(e + len + 4, 1'b1, 1'b1, 2'd1);
            lock1[b] = 1'b0;
            repeat (len) tick();
            lock1[b] = 1'b1;
            wait_until(e + len + 8);
        end

        repeat (5) tick();
        check("dut0_pending", q0.size() == 0, $sformatf("%0d events outstanding", q0.size()), "0 outstanding");
        check("dut1_pending", q1.size() == 0, $sformatf("%0d events outstanding", q1.size()), "0 outstanding");
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
